// File: rtl/serial_subtractor_if.sv
// Ready/valid operand and result bundle for serial_subtractor.
// master drives operands and accepts results; slave is the subtractor itself.
interface serial_subtractor_if #(
  parameter int N = 30
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic         Bin;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] Diff;
  logic         Bout;
  logic         Ovf;

  modport master (
    output in_valid, A, B, Bin, out_ready,
    input  in_ready, out_valid, Diff, Bout, Ovf
  );

  modport slave (
    input  in_valid, A, B, Bin, out_ready,
    output in_ready, out_valid, Diff, Bout, Ovf
  );
endinterface

// File: rtl/serial_subtractor.sv
// Digit-serial subtractor: Diff = A - B - Bin, D bits per clock, LSB digit first,
// borrow carried between digits in a register. One result per K+2 cycles.
module serial_subtractor #(
  parameter int N = 30,
  parameter int D = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  serial_subtractor_if.slave   s_if
);
  localparam int K  = N / D;
  localparam int CW = (K > 1) ? $clog2(K) : 1;
  localparam logic [CW-1:0] LAST = CW'(K - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [N-1:0]  r_a;
  logic [N-1:0]  r_b;
  logic          r_borrow;
  logic [N-1:0]  r_diff;
  logic          r_bout;
  logic          r_ovf;
  logic          r_out_valid;
  logic          r_in_ready;

  logic [D-1:0]  w_a_dig;
  logic [D-1:0]  w_b_dig;
  logic [D:0]    w_d;

  always_comb begin
    w_a_dig = '0;
    w_b_dig = '0;
    for (int k = 0; k < K; k++) begin
      if (r_cnt == CW'(k)) begin
        w_a_dig = r_a[k*D +: D];
        w_b_dig = r_b[k*D +: D];
      end
    end
  end

  // One extra bit so the sign of the digit difference is the outgoing borrow.
  assign w_d = {1'b0, w_a_dig} - {1'b0, w_b_dig} - {{D{1'b0}}, r_borrow};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_borrow    <= 1'b0;
      r_diff      <= '0;
      r_bout      <= 1'b0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (s_if.in_valid) begin
            r_a        <= s_if.A;
            r_b        <= s_if.B;
            r_borrow   <= s_if.Bin;
            r_cnt      <= '0;
            r_in_ready <= 1'b0;
            r_state    <= RUN;
          end
        end
        RUN: begin
          for (int k = 0; k < K; k++) begin
            if (r_cnt == CW'(k)) r_diff[k*D +: D] <= w_d[D-1:0];
          end
          r_borrow <= w_d[D];
          if (r_cnt == LAST) begin
            // w_d[D-1] is the new Diff MSB written on this same edge.
            r_bout      <= w_d[D];
            r_ovf       <= (r_a[N-1] != r_b[N-1]) && (w_d[D-1] != r_a[N-1]);
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        DONE: begin
          if (s_if.out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign s_if.in_ready  = r_in_ready;
  assign s_if.out_valid = r_out_valid;
  assign s_if.Diff      = r_diff;
  assign s_if.Bout      = r_bout;
  assign s_if.Ovf       = r_ovf;
endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and random checks of serial_subtractor (N=30, D=5) through its ready/valid bundle.
module tb_serial_subtractor;
  localparam int N = 30;
  localparam logic [N-1:0] ONES = '1;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  serial_subtractor_if #(.N(N)) bus ();

  serial_subtractor #(.N(N), .D(5)) dut (
    .clk  (clk),
    .rst  (rst),
    .s_if (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Accept one operand set, wait for out_valid, verify latency and in_ready.
  // inject pulses in_valid with junk operands during RUN.
  task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic bin,
                       input logic inject,
                       output logic [N-1:0] d, output logic bo, output logic ov);
    int  lat;
    logic busy_ok;
    bus.A = a; bus.B = b; bus.Bin = bin; bus.in_valid = 1'b1;
    check("in_ready_idle", 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 0;
    busy_ok = 1'b1;
    while (!bus.out_valid && lat < 20) begin
      if (bus.in_ready !== 1'b0) busy_ok = 1'b0;
      if (inject && (lat == 1 || lat == 2)) begin
        bus.A = ~a; bus.B = a; bus.Bin = ~bin; bus.in_valid = 1'b1;
      end else begin
        bus.in_valid = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    bus.in_valid = 1'b0;
    check("in_ready_run", 64'(busy_ok), 64'd1);
    check("latency", 64'(lat), 64'd6);
    check("in_ready_done", 64'(bus.in_ready), 64'd0);
    d  = bus.Diff;
    bo = bus.Bout;
    ov = bus.Ovf;
  endtask

  task automatic handoff();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("out_valid_after_handoff", 64'(bus.out_valid), 64'd0);
    check("in_ready_after_handoff", 64'(bus.in_ready), 64'd1);
  endtask

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         bin;
    logic [N-1:0] diff;
    logic         bout;
    logic         ovf;
  } vec_t;

  vec_t vecs[7];

  initial begin
    logic [N-1:0] d;
    logic         bo, ov;
    logic [N:0]   wide;
    logic [N-1:0] ra, rb, exp_d;
    logic         rbin, exp_bo, exp_ov;
    logic         hold_ok, nov_ok;

    n_checks = 0;
    n_fail   = 0;
    clk = 1'b0;
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.A = '0; bus.B = '0; bus.Bin = 1'b0; bus.out_ready = 1'b0;

    vecs[0] = '{30'd100,      30'd30,       1'b0, 30'd70,       1'b0, 1'b0};
    vecs[1] = '{30'd0,        30'd1,        1'b0, 30'h3FFFFFFF, 1'b1, 1'b0};
    vecs[2] = '{30'd5,        30'd5,        1'b1, 30'h3FFFFFFF, 1'b1, 1'b0};
    vecs[3] = '{30'h20000000, 30'd1,        1'b0, 30'h1FFFFFFF, 1'b0, 1'b1};
    vecs[4] = '{30'h1FFFFFFF, 30'h3FFFFFFF, 1'b0, 30'h20000000, 1'b1, 1'b1};
    vecs[5] = '{30'h3FFFFFFF, 30'd0,        1'b1, 30'h3FFFFFFE, 1'b0, 1'b0};
    vecs[6] = '{30'h2AAAAAAA, 30'h15555555, 1'b0, 30'h15555555, 1'b0, 1'b1};

    #12;
    check("rst_diff", 64'(bus.Diff), 64'd0);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_bout_ovf", 64'({bus.Bout, bus.Ovf}), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    foreach (vecs[i]) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].bin, 1'b0, d, bo, ov);
      $display("directed %0d: A=%0h B=%0h Bin=%0b -> Diff=%0h Bout=%0b Ovf=%0b",
               i, vecs[i].a, vecs[i].b, vecs[i].bin, d, bo, ov);
      check("dir_diff", 64'(d), 64'(vecs[i].diff));
      check("dir_bout", 64'(bo), 64'(vecs[i].bout));
      check("dir_ovf", 64'(ov), 64'(vecs[i].ovf));
      handoff();
    end

    // Backpressure: results held for 10 cycles while in_valid is pulsed.
    do_op(30'd1000, 30'd1, 1'b0, 1'b0, d, bo, ov);
    check("bp_diff", 64'(d), 64'd999);
    hold_ok = 1'b1;
    for (int c = 0; c < 10; c++) begin
      bus.A = 30'd7; bus.B = 30'd3; bus.Bin = 1'b1; bus.in_valid = c[0];
      @(posedge clk); #1;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.Diff !== 30'd999 ||
          bus.Bout !== 1'b0 || bus.Ovf !== 1'b0) hold_ok = 1'b0;
    end
    bus.in_valid = 1'b0;
    $display("backpressure: Diff=%0h held=%0b", bus.Diff, hold_ok);
    check("bp_hold", 64'(hold_ok), 64'd1);
    handoff();

    // Busy input: in_valid pulses during RUN must not disturb the operation.
    do_op(30'd50, 30'd8, 1'b0, 1'b1, d, bo, ov);
    $display("busy input: Diff=%0h Bout=%0b", d, bo);
    check("busy_diff", 64'(d), 64'd42);
    check("busy_bout", 64'(bo), 64'd0);
    handoff();

    // Asynchronous reset during RUN cycle 3.
    bus.A = 30'd777; bus.B = 30'd7; bus.Bin = 1'b0; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    $display("reset mid-run: Diff=%0h out_valid=%0b in_ready=%0b", bus.Diff, bus.out_valid, bus.in_ready);
    check("arst_diff", 64'(bus.Diff), 64'd0);
    check("arst_out_valid", 64'(bus.out_valid), 64'd0);
    check("arst_in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    nov_ok = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (bus.out_valid !== 1'b0) nov_ok = 1'b0;
    end
    check("arst_no_out_valid", 64'(nov_ok), 64'd1);
    do_op(30'h123, 30'h23, 1'b0, 1'b0, d, bo, ov);
    $display("after reset: Diff=%0h", d);
    check("post_rst_diff", 64'(d), 64'h100);
    handoff();

    // Random operand sets against a wide-arithmetic reference.
    for (int t = 0; t < 256; t++) begin
      ra   = N'($urandom);
      rb   = N'($urandom);
      rbin = 1'($urandom_range(1));
      wide = {1'b0, ra} - {1'b0, rb} - {{N{1'b0}}, rbin};
      exp_d  = wide[N-1:0];
      exp_bo = ({1'b0, ra} < ({1'b0, rb} + {{N{1'b0}}, rbin}));
      exp_ov = (ra[N-1] != rb[N-1]) && (exp_d[N-1] != ra[N-1]);
      do_op(ra, rb, rbin, 1'b0, d, bo, ov);
      $display("random %0d: A=%0h B=%0h Bin=%0b -> Diff=%0h Bout=%0b Ovf=%0b",
               t, ra, rb, rbin, d, bo, ov);
      check("rnd_diff", 64'(d), 64'(exp_d));
      check("rnd_bout", 64'(bo), 64'(exp_bo));
      check("rnd_ovf", 64'(ov), 64'(exp_ov));
      handoff();
    end

    check("ones_const_width", 64'(ONES), 64'h3FFFFFFF);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
